// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the unified-memory port arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_ack, if_rdata, if_err,
    output dm_ack, dm_rdata, dm_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_ack, if_rdata, if_err,
    input  dm_ack, dm_rdata, dm_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with data
// priority, a bounded fetch-starvation streak and a memory-ack watchdog.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_IF,
    MEM_DM,
    RESP
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [7:0] TO_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       dm_win;
  logic       to_hit;

  always_comb begin
    dm_win = bus.dm_req && (!bus.if_req || (streak < STREAK_MAX));
    to_hit = (TIMEOUT != 0) && (tcnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      streak        <= '0;
      tcnt          <= '0;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_err    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.dm_err    <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          // The mem_* registers double as the latched copy of the granted request.
          if (dm_win) begin
            state         <= MEM_DM;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_be    <= bus.dm_be;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            if (!bus.if_req) begin
              streak <= '0;
            end else if (streak < STREAK_MAX) begin
              streak <= streak + 4'd1;
            end
          end else if (bus.if_req) begin
            state         <= MEM_IF;
            streak        <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'hF;
            bus.mem_addr  <= {bus.if_addr[31:2], 2'b00};
            bus.mem_wdata <= '0;
          end
        end

        MEM_IF, MEM_DM: begin
          // mem_ack takes precedence over a watchdog expiry in the same cycle.
          if (bus.mem_ack || to_hit) begin
            state         <= RESP;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (state == MEM_DM) begin
              bus.dm_ack   <= 1'b1;
              bus.dm_err   <= !bus.mem_ack;
              bus.dm_rdata <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_err   <= !bus.mem_ack;
              bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        RESP: begin
          state        <= IDLE;
          bus.if_ack   <= 1'b0;
          bus.if_rdata <= '0;
          bus.if_err   <= 1'b0;
          bus.dm_ack   <= 1'b0;
          bus.dm_rdata <= '0;
          bus.dm_err   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requester/memory stimulus,
// expected memory transactions and responses checked by a negedge monitor.
module tb_mem_port_arbiter;

  typedef struct {
    bit          dm;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } memx_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n2_ack = 0;

  resp_t exp_resp[$];
  memx_t exp_mem[$];

  // memory responder controls
  bit          mem_en = 1'b1;
  bit          force_ack = 1'b0;
  int          ack_delay = 0;
  int          mcnt = 0;
  logic [31:0] mem_data = '0;

  bit if_pend = 1'b0;
  bit dm_pend = 1'b0;
  bit mreq_q  = 1'b0;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus2 ();

  mem_port_arbiter #(.MAX_DM_STREAK(4), .TIMEOUT(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_port_arbiter #(.MAX_DM_STREAK(4), .TIMEOUT(0)) u_nto (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [137:0] act, input logic [137:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string nm);
    chk(nm, {bus.if_ack, bus.if_rdata, bus.if_err, bus.dm_ack, bus.dm_rdata, bus.dm_err,
             bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, '0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_mem(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input int c);
    memx_t m;
    m.we = we; m.be = be; m.addr = addr; m.wdata = wdata; m.cyc = c;
    exp_mem.push_back(m);
  endtask

  task automatic push_resp(input bit dm, input logic [31:0] rdata, input bit err, input int c);
    resp_t r;
    r.dm = dm; r.rdata = rdata; r.err = err; r.cyc = c;
    exp_resp.push_back(r);
  endtask

  // Memory model: acks ack_delay cycles into an access with mem_data ^ mem_addr.
  always @(negedge clk) begin
    if (bus.mem_req && mem_en && (mcnt >= ack_delay)) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mem_data ^ bus.mem_addr;
    end else if (force_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0BAD_0BAD;
    end
    mcnt = bus.mem_req ? mcnt + 1 : 0;
  end

  // Monitor: memory-side transactions, requester responses, requester protocol.
  always @(negedge clk) begin
    resp_t r;
    memx_t m;
    if (bus.if_ack || bus.dm_ack) begin
      chk("ack_exclusive", bus.if_ack & bus.dm_ack, 0);
      if (exp_resp.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b, expected none (cycle %0d)",
                 bus.if_ack, bus.dm_ack, cyc);
      end else begin
        r = exp_resp.pop_front();
        chk("resp_port_dm", bus.dm_ack, r.dm);
        chk("resp_cycle", cyc, r.cyc);
        chk("resp_rdata", r.dm ? bus.dm_rdata : bus.if_rdata, r.rdata);
        chk("resp_err", r.dm ? bus.dm_err : bus.if_err, r.err);
        chk("other_err", r.dm ? bus.if_err : bus.dm_err, 0);
      end
    end
    if (bus.mem_req && !mreq_q) begin
      if (exp_mem.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_mem_req: got mem_req=1, expected 0 (cycle %0d)", cyc);
      end else begin
        m = exp_mem.pop_front();
        chk("mem_cycle", cyc, m.cyc);
        chk("mem_fields", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
            {m.we, m.be, m.addr, m.wdata});
      end
    end
    mreq_q = bus.mem_req;
    if (!reset) begin
      if_pend = 1'b0;
      dm_pend = 1'b0;
    end else begin
      if (if_pend) chk("proto_if_req_held", bus.if_req, 1);
      if (dm_pend) chk("proto_dm_req_held", bus.dm_req, 1);
      if_pend = bus.if_req && !bus.if_ack;
      dm_pend = bus.dm_req && !bus.dm_ack;
    end
    if (bus2.if_ack || bus2.dm_ack) n2_ack++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "tb_mem_port_arbiter stalled");
  end

  initial begin
    int n0;
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus2.if_req = 1'b0; bus2.if_addr = '0;
    bus2.dm_req = 1'b0; bus2.dm_we = 1'b0; bus2.dm_be = 4'hF; bus2.dm_addr = 32'h40;
    bus2.dm_wdata = '0; bus2.mem_ack = 1'b0; bus2.mem_rdata = '0;
    tick(3);
    check_zero("reset_outputs");
    reset = 1'b1;
    bus2.dm_req = 1'b1;
    tick(1);

    // basic fetch, word-aligned address
    n0 = cyc;
    mem_data = 32'hDEADBEEF ^ 32'h0000_0104;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0106;
    push_mem(1'b0, 4'hF, 32'h0000_0104, 32'h0, n0 + 1);
    push_resp(1'b0, 32'hDEADBEEF, 1'b0, n0 + 2);
    tick(3);
    chk("fetch_back_idle", {bus.if_ack, bus.mem_req}, 0);
    bus.if_req = 1'b0;
    tick(1);

    // simultaneous requests: data first, then fetch
    n0 = cyc;
    mem_data = 32'h5A5A_0000;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0203;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF;
    bus.dm_addr = 32'h0000_0301; bus.dm_wdata = 32'hFFFF_0000;
    push_mem(1'b0, 4'hF, 32'h0000_0301, 32'hFFFF_0000, n0 + 1);
    push_resp(1'b1, 32'h5A5A_0301, 1'b0, n0 + 2);
    push_mem(1'b0, 4'hF, 32'h0000_0200, 32'h0, n0 + 4);
    push_resp(1'b0, 32'h5A5A_0200, 1'b0, n0 + 5);
    tick(3);
    bus.dm_req = 1'b0;
    tick(3);
    bus.if_req = 1'b0;
    tick(1);

    // starvation bound: DM,DM,DM,DM,IF twice
    n0 = cyc;
    mem_data = 32'h0;
    bus.dm_addr = 32'h0000_0400; bus.dm_wdata = 32'h0; bus.dm_be = 4'hF; bus.dm_we = 1'b0;
    bus.if_addr = 32'h0000_0500;
    bus.dm_req = 1'b1; bus.if_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 != 4) begin
        push_mem(1'b0, 4'hF, 32'h0000_0400, 32'h0, n0 + 3 * k + 1);
        push_resp(1'b1, 32'h0000_0400, 1'b0, n0 + 3 * k + 2);
      end else begin
        push_mem(1'b0, 4'hF, 32'h0000_0500, 32'h0, n0 + 3 * k + 1);
        push_resp(1'b0, 32'h0000_0500, 1'b0, n0 + 3 * k + 2);
      end
    end
    tick(27);
    bus.dm_req = 1'b0;
    tick(3);
    bus.if_req = 1'b0;
    tick(1);

    // store pass-through, rdata forced to zero
    n0 = cyc;
    mem_data = 32'hCAFE_F00D;
    bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
    bus.dm_addr = 32'h0000_2002; bus.dm_wdata = 32'h1234_ABCD; bus.dm_req = 1'b1;
    push_mem(1'b1, 4'b0011, 32'h0000_2002, 32'h1234_ABCD, n0 + 1);
    push_resp(1'b1, 32'h0, 1'b0, n0 + 2);
    tick(3);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    tick(1);

    // reset during MEM_DM drops the access
    n0 = cyc;
    mem_en = 1'b0;
    bus.dm_be = 4'hF; bus.dm_addr = 32'h0000_0700; bus.dm_wdata = 32'h0; bus.dm_req = 1'b1;
    push_mem(1'b0, 4'hF, 32'h0000_0700, 32'h0, n0 + 1);
    tick(3);
    reset = 1'b0; bus.dm_req = 1'b0;
    tick(1);
    check_zero("reset_mid_outputs");
    reset = 1'b1; force_ack = 1'b1;
    tick(2);
    force_ack = 1'b0; mem_en = 1'b1;
    tick(1);
    n0 = cyc;
    mem_data = 32'h0F0F_0000;
    bus.if_addr = 32'h0000_0804; bus.if_req = 1'b1;
    push_mem(1'b0, 4'hF, 32'h0000_0804, 32'h0, n0 + 1);
    push_resp(1'b0, 32'h0F0F_0804, 1'b0, n0 + 2);
    tick(3);
    bus.if_req = 1'b0;
    tick(1);

    // watchdog expiry after 16 MEM cycles; late ack ignored
    n0 = cyc;
    mem_en = 1'b0;
    bus.dm_be = 4'hC; bus.dm_addr = 32'h0000_0600; bus.dm_req = 1'b1;
    push_mem(1'b0, 4'hC, 32'h0000_0600, 32'h0, n0 + 1);
    push_resp(1'b1, 32'h0, 1'b1, n0 + 17);
    tick(16);
    chk("timeout_mem_req_last", bus.mem_req, 1);
    tick(1);
    chk("timeout_mem_req_drop", bus.mem_req, 0);
    force_ack = 1'b1;
    tick(1);
    bus.dm_req = 1'b0;
    tick(2);
    force_ack = 1'b0; mem_en = 1'b1;

    // ack in the same cycle the watchdog expires: no error
    n0 = cyc;
    ack_delay = 15;
    mem_data = 32'h1111_0000;
    bus.dm_be = 4'hF; bus.dm_addr = 32'h0000_0640; bus.dm_req = 1'b1;
    push_mem(1'b0, 4'hF, 32'h0000_0640, 32'h0, n0 + 1);
    push_resp(1'b1, 32'h1111_0640, 1'b0, n0 + 17);
    tick(18);
    bus.dm_req = 1'b0; ack_delay = 0;
    tick(2);

    // TIMEOUT=0 instance has held its access without ever acking
    chk("nto_mem_req_held", bus2.mem_req, 1);
    chk("nto_no_ack", n2_ack, 0);
    chk("resp_queue_drained", exp_resp.size(), 0);
    chk("mem_queue_drained", exp_mem.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
